// File: rtl/dff_sync_multi.sv
// dff_sync_multi: multi-channel Gray pointer synchroniser with binary decode, change pulses and settle tracking; DFF_SYNC_GRAY_CHECK_EN adds sticky multi-bit-step detection
module dff_sync_multi #(
   parameter int PTR_WIDTH   = 4,
   parameter int SYNC_STAGES = 2,
   parameter int NUM_CH      = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH*PTR_WIDTH-1:0] async_gray,
   input  logic                        err_clr,
   output logic [NUM_CH*PTR_WIDTH-1:0] sync_gray,
   output logic [NUM_CH*PTR_WIDTH-1:0] sync_bin,
   output logic                        sync_valid,
   output logic [NUM_CH-1:0]           ptr_chg,
   output logic [NUM_CH-1:0]           gray_err
);
   localparam int W  = NUM_CH*PTR_WIDTH;
   localparam int CW = $clog2(SYNC_STAGES+2);
   typedef enum logic {SETTLE, VALID} state_t;
   logic [W-1:0]      stage_q [SYNC_STAGES];
   logic [W-1:0]      prev_q, bin_q, bin_d;
   logic [NUM_CH-1:0] chg_q, chg_d;
   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic              valid_q;
   assign sync_gray  = stage_q[SYNC_STAGES-1];
   assign sync_bin   = bin_q;
   assign sync_valid = valid_q;
   assign ptr_chg    = chg_q;
   // cascaded synchroniser flops, one chain per pointer bit
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      else begin
         stage_q[0] <= async_gray;
         for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
   // Gray decode (each binary bit is the parity of the Gray bits at and above it) and change detection
   always_comb begin
      bin_d = '0;
      chg_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int i = 0; i < PTR_WIDTH; i++) bin_d[c*PTR_WIDTH+i] = ^(sync_gray[c*PTR_WIDTH +: PTR_WIDTH] >> i);
         chg_d[c] = valid_q && (sync_gray[c*PTR_WIDTH +: PTR_WIDTH] != prev_q[c*PTR_WIDTH +: PTR_WIDTH]);
      end
   end
   // binary output, change pulse and previous-pointer registers update together
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bin_q  <= '0;
         prev_q <= '0;
         chg_q  <= '0;
      end else begin
         bin_q  <= bin_d;
         prev_q <= sync_gray;
         chg_q  <= chg_d;
      end
   // settle FSM: count edges after reset until the chain and decode stage hold real data
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= SETTLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else if (state_q == SETTLE) begin
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == CW'(SYNC_STAGES)) begin
            state_q <= VALID;
            valid_q <= 1'b1;
         end
      end
`ifdef DFF_SYNC_GRAY_CHECK_EN
   logic [NUM_CH-1:0] err_q, err_set;
   assign gray_err = err_q;
   // a legal Gray step flips at most one bit between consecutive synchronised samples
   always_comb begin
      err_set = '0;
      for (int c = 0; c < NUM_CH; c++)
         err_set[c] = valid_q && ($countones(sync_gray[c*PTR_WIDTH +: PTR_WIDTH] ^ prev_q[c*PTR_WIDTH +: PTR_WIDTH]) > 1);
   end
   // sticky error flags; a new error in the clear cycle survives the clear
   always_ff @(posedge clk or posedge rst)
      if (rst) err_q <= '0;
      else     err_q <= err_set | (err_q & ~{NUM_CH{err_clr}});
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign gray_err       = '0;
`endif
endmodule

// File: tb/tb_dff_sync_multi.sv
// tb_dff_sync_multi: randomized check of dff_sync_multi against a history-based reference model
module tb_dff_sync_multi;
   localparam int PW = 4, S = 3, N = 4, NB = N*PW;
   logic          clk = 1'b0, rst = 1'b0, err_clr = 1'b0;
   logic [NB-1:0] async_gray = '0;
   logic [NB-1:0] sync_gray, sync_bin;
   logic          sync_valid;
   logic [N-1:0]  ptr_chg, gray_err;
   logic [NB-1:0] hist [4096];
   logic [N-1:0]  err_m;
   logic [NB-1:0] cur;
   int            n, tests, fails;

   dff_sync_multi #(.PTR_WIDTH(PW), .SYNC_STAGES(S), .NUM_CH(N)) dut (
      .clk(clk), .rst(rst), .async_gray(async_gray), .err_clr(err_clr),
      .sync_gray(sync_gray), .sync_bin(sync_bin), .sync_valid(sync_valid),
      .ptr_chg(ptr_chg), .gray_err(gray_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, n);
      end
   endtask

   // async_gray value present at edge k since the last reset; nothing before edge 1
   function automatic logic [NB-1:0] g(input int k);
      return (k < 1) ? '0 : hist[k];
   endfunction

   // decode each channel by searching for the binary count whose Gray code matches
   function automatic logic [NB-1:0] to_bin(input logic [NB-1:0] v);
      logic [NB-1:0] r = '0;
      for (int c = 0; c < N; c++)
         for (int b = 0; b < (1 << PW); b++)
            if (PW'(b ^ (b >> 1)) == v[c*PW +: PW]) r[c*PW +: PW] = PW'(b);
      return r;
   endfunction

   task automatic step(input logic [NB-1:0] a, input logic c);
      logic [N-1:0] chg_e;
      logic [PW-1:0] o, w;
      logic ov;
      async_gray = a;
      err_clr    = c;
      n++;
      hist[n] = a;
      @(posedge clk);
      @(negedge clk);
      ov = (n - 1) >= S + 1;
      for (int ch = 0; ch < N; ch++) begin
         o = g(n-S-1)[ch*PW +: PW];
         w = g(n-S)[ch*PW +: PW];
         chg_e[ch] = ov && (o != w);
`ifdef DFF_SYNC_GRAY_CHECK_EN
         err_m[ch] = (ov && $countones(o ^ w) > 1) || (err_m[ch] && !c);
`else
         err_m[ch] = 1'b0;
`endif
      end
      check("sync_gray", 32'(sync_gray), 32'(g(n-S+1)));
      check("sync_bin", 32'(sync_bin), 32'(to_bin(g(n-S))));
      check("sync_valid", 32'(sync_valid), 32'(n >= S + 1));
      check("ptr_chg", 32'(ptr_chg), 32'(chg_e));
      check("gray_err", 32'(gray_err), 32'(err_m));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_gray"}, 32'(sync_gray), 32'd0);
      check({tag, "_bin"}, 32'(sync_bin), 32'd0);
      check({tag, "_valid"}, 32'(sync_valid), 32'd0);
      check({tag, "_chg"}, 32'(ptr_chg), 32'd0);
      check({tag, "_err"}, 32'(gray_err), 32'd0);
   endtask

   task automatic rand_step();
      int r, b1, b2;
      for (int ch = 0; ch < N; ch++) begin
         r = $urandom_range(0, 9);
         if (r >= 4 && r < 9) cur[ch*PW + $urandom_range(0, PW-1)] ^= 1'b1;
         else if (r == 9) begin
            b1 = $urandom_range(0, PW-1);
            b2 = (b1 + 1 + $urandom_range(0, PW-2)) % PW;
            cur[ch*PW + b1] ^= 1'b1;
            cur[ch*PW + b2] ^= 1'b1;
         end
      end
      step(cur, $urandom_range(0, 7) == 0);
   endtask

   initial begin
      tests = 0; fails = 0; n = 0; err_m = '0;
      #1 rst = 1'b1;
      #2 check_zero("por");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (S + 2) step('0, 1'b0);
      repeat (5) step(16'h0001, 1'b0);
      repeat (5) step(16'h0000, 1'b0);
      repeat (5) step(16'h0008, 1'b0);
      repeat (5) step(16'h0000, 1'b0);
      repeat (5) step(16'h0101, 1'b0);
      repeat (5) step(16'h0000, 1'b0);
      repeat (6) step(16'h0003, 1'b0);
      step(16'h0003, 1'b1);
      repeat (3) step(16'h0003, 1'b0);
      repeat (5) step(16'h0000, 1'b1);
      repeat (3) step(16'h0000, 1'b0);
      cur = '0;
      repeat (300) rand_step();
      cur = ~cur;
      step(cur, 1'b0);
      #2 rst = 1'b1;
      #1 check_zero("midrst");
      #1 rst = 1'b0;
      n = 0; err_m = '0;
      repeat (300) rand_step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
